// File: rtl/values_mem_loader.sv
`timescale 1ns/1ps
// values_mem_loader: packs a byte stream (MSB first) into DATA_WIDTH words
// and writes word i to bank (i mod NUM_VAL_MEMS), row (i div NUM_VAL_MEMS).
// Banks at or above CHANGE_INDEX hold one row less and are skipped on the
// last row.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin a load (honoured in IDLE/DONE)
//   s_data/s_valid/s_ready byte stream with valid/ready handshake
//   wr_en/wr_bank/wr_addr/wr_data  one-cycle write strobe and its target
//   busy, done            load in progress / load complete
module values_mem_loader #(
   parameter int NUM_VAL_MEMS = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_W       = 2,
   parameter int FILE_LENGTH  = 3,
   parameter int CHANGE_INDEX = 2,
   localparam int BANK_W = (NUM_VAL_MEMS > 1) ? $clog2(NUM_VAL_MEMS) : 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [BANK_W-1:0]     wr_bank,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done
);

   localparam int BPW   = (DATA_WIDTH + 7) / 8;
   localparam int PW    = (BPW > 1) ? (BPW - 1) * 8 : 8;
   localparam int TOTAL = (CHANGE_INDEX >= 0)
                        ? NUM_VAL_MEMS * FILE_LENGTH - (NUM_VAL_MEMS - CHANGE_INDEX)
                        : NUM_VAL_MEMS * FILE_LENGTH;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int BC_W  = $clog2(BPW + 1);

   localparam logic [BANK_W-1:0] LAST_FULL  = BANK_W'(NUM_VAL_MEMS - 1);
   localparam logic [BANK_W-1:0] LAST_SHORT =
      BANK_W'((CHANGE_INDEX > 0) ? CHANGE_INDEX - 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(FILE_LENGTH - 1);
   localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(TOTAL - 1);
   localparam logic [BC_W-1:0]   LAST_BYTE  = BC_W'(BPW - 1);

   if (CHANGE_INDEX >= NUM_VAL_MEMS) begin : g_bad_change_index
      $error("values_mem_loader: CHANGE_INDEX must be < NUM_VAL_MEMS");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  r_state;
   logic [BC_W-1:0]         r_byte_cnt;
   logic [CNT_W-1:0]        r_word_cnt;
   logic [PW-1:0]           r_shreg;
   logic [BANK_W-1:0]       r_bank;
   logic [ADDR_W-1:0]       r_row;
   logic                    r_s_ready;
   logic                    r_wr_en;
   logic [BANK_W-1:0]       r_wr_bank;
   logic [ADDR_W-1:0]       r_wr_addr;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic                    r_busy;
   logic                    r_done;

   logic [PW+7:0]           w_shreg_nxt;
   logic [BANK_W-1:0]       w_bank_end;
   logic                    w_accept;

   // Only the earlier bytes of the word are kept; the incoming byte is
   // appended combinationally so the full word is ready on the last accept.
   assign w_shreg_nxt = {r_shreg, s_data};
   assign w_accept    = s_valid && r_s_ready;

   // Short banks end the last row early.
   assign w_bank_end = (CHANGE_INDEX >= 0 && r_row == LAST_ROW)
                     ? LAST_SHORT : LAST_FULL;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= '0;
         r_word_cnt <= '0;
         r_shreg    <= '0;
         r_bank     <= '0;
         r_row      <= '0;
         r_s_ready  <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_bank  <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_COLLECT;
                  r_byte_cnt <= '0;
                  r_word_cnt <= '0;
                  r_shreg    <= '0;
                  r_bank     <= '0;
                  r_row      <= '0;
                  r_s_ready  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  r_shreg <= w_shreg_nxt[PW-1:0];
                  if (r_byte_cnt == LAST_BYTE) begin
                     r_byte_cnt <= '0;
                     r_state    <= S_WRITE;
                     r_s_ready  <= 1'b0;
                     r_wr_en    <= 1'b1;
                     r_wr_bank  <= r_bank;
                     r_wr_addr  <= r_row;
                     r_wr_data  <= w_shreg_nxt[DATA_WIDTH-1:0];
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               r_wr_en    <= 1'b0;
               r_word_cnt <= r_word_cnt + 1'b1;
               if (r_bank == w_bank_end) begin
                  r_bank <= '0;
                  r_row  <= r_row + 1'b1;
               end else begin
                  r_bank <= r_bank + 1'b1;
               end
               if (r_word_cnt == LAST_WORD) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= S_COLLECT;
                  r_s_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready = r_s_ready;
   assign wr_en   = r_wr_en;
   assign wr_bank = r_wr_bank;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule
